rv64g_l1_vlsu_refill_engine: RTL and testbench



---
 rtl/rv64g_l1_vlsu_refill_engine_pkg.sv | 50 +++++
 rtl/rv64g_l1_vlsu_refill_engine.sv | 213 +++++++++++++++++++++
 tb/tb_rv64g_l1_vlsu_refill_engine.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv64g_l1_vlsu_refill_engine_pkg.sv
// Shared definitions for the L1 VLSU refill engine: TileLink-C opcode and
// param encodings, line geometry, L1 permission encoding and FSM states.
package rv64g_l1_vlsu_refill_engine_pkg;

  // Line geometry
  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned LOG2_LINE  = 6;

  // TileLink opcodes used by this engine
  localparam logic [2:0] TL_A_ACQUIRE_BLOCK = 3'd6;
  localparam logic [2:0] TL_D_GRANT         = 3'd4;
  localparam logic [2:0] TL_D_GRANT_DATA    = 3'd5;

  // Acquire (Grow) param encodings on channel A
  localparam logic [2:0] TL_GROW_NTOB = 3'd0;
  localparam logic [2:0] TL_GROW_NTOT = 3'd1;

  // Cap param encodings on channel D
  localparam logic [1:0] TL_CAP_TOT = 2'd0;
  localparam logic [1:0] TL_CAP_TOB = 2'd1;
  localparam logic [1:0] TL_CAP_TON = 2'd2;

  // L1 permission encoding stored alongside the tag
  localparam logic [1:0] L1_PERM_N = 2'd0;
  localparam logic [1:0] L1_PERM_B = 2'd1;
  localparam logic [1:0] L1_PERM_T = 2'd2;

  // Transfer size field for one full line (log2 of bytes)
  localparam logic [3:0] TL_SIZE_LINE = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACQ   = 3'd1,
    ST_GRANT = 3'd2,
    ST_ACK   = 3'd3,
    ST_DONE  = 3'd4
  } refill_state_e;

  // Map the granted cap onto the permission written into the tag array.
  function automatic logic [1:0] cap_to_perm(input logic [1:0] cap);
    logic [1:0] perm;
    case (cap)
      TL_CAP_TOT: perm = L1_PERM_T;
      TL_CAP_TOB: perm = L1_PERM_B;
      default:    perm = L1_PERM_N;
    endcase
    return perm;
  endfunction

endpackage

// File: rtl/rv64g_l1_vlsu_refill_engine.sv
// L1 VLSU refill engine: turns one refill request into a single TileLink-C
// AcquireBlock / GrantData / GrantAck exchange, streams the line into the
// data array, writes tag and permission, and pulses completion.
module rv64g_l1_vlsu_refill_engine
  import rv64g_l1_vlsu_refill_engine_pkg::*;
#(
  parameter int unsigned TAG_W     = 53,
  parameter int unsigned INDEX_W   = 5,
  parameter int unsigned WAY_W     = 2,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned SRC_W     = 4,
  parameter int unsigned SINK_W    = 4,
  parameter int unsigned SOURCE_ID = 0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  // Miss handler side
  input  logic               refill_req_i,
  input  logic [63:0]        refill_addr_i,
  input  logic               refill_excl_i,
  input  logic [WAY_W-1:0]   victim_way_i,
  output logic               refill_done_o,
  output logic               refill_err_o,
  output logic               busy_o,
  // TL-A
  output logic               a_valid_o,
  input  logic               a_ready_i,
  output logic [2:0]         a_opcode_o,
  output logic [2:0]         a_param_o,
  output logic [3:0]         a_size_o,
  output logic [SRC_W-1:0]   a_source_o,
  output logic [63:0]        a_address_o,
  // TL-D
  input  logic               d_valid_i,
  output logic               d_ready_o,
  input  logic [2:0]         d_opcode_i,
  input  logic [1:0]         d_param_i,
  input  logic [SRC_W-1:0]   d_source_i,
  input  logic [SINK_W-1:0]  d_sink_i,
  input  logic               d_denied_i,
  input  logic               d_corrupt_i,
  input  logic [DATA_W-1:0]  d_data_i,
  // TL-E
  output logic               e_valid_o,
  input  logic               e_ready_i,
  output logic [SINK_W-1:0]  e_sink_o,
  // L1 data array write port
  output logic               data_we_o,
  output logic [INDEX_W-1:0] data_index_o,
  output logic [WAY_W-1:0]   data_way_o,
  output logic [2:0]         data_beat_o,
  output logic [DATA_W-1:0]  data_wdata_o,
  // L1 tag array write port
  output logic               tag_we_o,
  output logic [TAG_W-1:0]   tag_o,
  output logic [1:0]         tag_perm_o
);

  localparam int unsigned     LINE_W    = 64 - LOG2_LINE;
  localparam int unsigned     BEATS     = (LINE_BYTES * 8) / DATA_W;
  localparam logic [2:0]      LAST_BEAT = 3'(BEATS - 1);
  localparam logic [SRC_W-1:0] SRC_ID   = SRC_W'(SOURCE_ID);

  // Latched request and transaction state
  refill_state_e       state_q;
  logic [LINE_W-1:0]   line_q;
  logic                excl_q;
  logic [WAY_W-1:0]    way_q;
  logic [2:0]          beat_q;
  logic                err_q;
  logic [SINK_W-1:0]   sink_q;
  logic [1:0]          param_q;

  // Registered handshake and pulse outputs
  logic                a_valid_q;
  logic                d_ready_q;
  logic                e_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                done_err_q;

  // Per-beat decode of channel D
  logic                d_hs_s;
  logic                is_data_s;
  logic                beat_err_s;
  logic                err_now_s;
  logic                last_beat_s;
  logic                unused_addr_s;

  // The byte offset within the line carries no information for a full-line fill.
  assign unused_addr_s = ^refill_addr_i[LOG2_LINE-1:0];

  assign d_hs_s      = d_ready_q & d_valid_i;
  assign is_data_s   = (d_opcode_i == TL_D_GRANT_DATA);
  // Anything other than GrantData (Grant or an unknown opcode) is a bad
  // grant for a line refill and ends the D phase after that single beat.
  assign beat_err_s  = d_denied_i | d_corrupt_i | (d_source_i != SRC_ID) |
                       ~is_data_s | (d_param_i == TL_CAP_TON);
  assign err_now_s   = err_q | beat_err_s;
  assign last_beat_s = ~is_data_s | (beat_q == LAST_BEAT);

  // Control FSM: sequences the A, D and E channels and owns all registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      line_q     <= {LINE_W{1'b0}};
      excl_q     <= 1'b0;
      way_q      <= {WAY_W{1'b0}};
      beat_q     <= 3'd0;
      err_q      <= 1'b0;
      sink_q     <= {SINK_W{1'b0}};
      param_q    <= 2'd0;
      a_valid_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      e_valid_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (refill_req_i) begin
            line_q    <= refill_addr_i[63:LOG2_LINE];
            excl_q    <= refill_excl_i;
            way_q     <= victim_way_i;
            a_valid_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_ACQ;
          end
        end
        ST_ACQ: begin
          if (a_ready_i) begin
            a_valid_q <= 1'b0;
            d_ready_q <= 1'b1;
            beat_q    <= 3'd0;
            err_q     <= 1'b0;
            state_q   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (d_hs_s) begin
            beat_q <= beat_q + 3'd1;
            err_q  <= err_now_s;
            if (beat_q == 3'd0) begin
              sink_q  <= d_sink_i;
              param_q <= d_param_i;
            end
            if (last_beat_s) begin
              d_ready_q <= 1'b0;
              e_valid_q <= 1'b1;
              state_q   <= ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (e_ready_i) begin
            e_valid_q  <= 1'b0;
            done_q     <= 1'b1;
            done_err_q <= err_q;
            state_q    <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          a_valid_q <= 1'b0;
          d_ready_q <= 1'b0;
          e_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Miss handler status
  assign refill_done_o = done_q;
  assign refill_err_o  = done_err_q;
  assign busy_o        = busy_q;

  // Channel A: fields come straight from the latched request, so they stay
  // stable for as long as a_valid_o waits on a_ready_i.
  assign a_valid_o   = a_valid_q;
  assign a_opcode_o  = TL_A_ACQUIRE_BLOCK;
  assign a_param_o   = excl_q ? TL_GROW_NTOT : TL_GROW_NTOB;
  assign a_size_o    = TL_SIZE_LINE;
  assign a_source_o  = SRC_ID;
  assign a_address_o = {line_q, {LOG2_LINE{1'b0}}};

  // Channels D and E
  assign d_ready_o = d_ready_q;
  assign e_valid_o = e_valid_q;
  assign e_sink_o  = sink_q;

  // Data array: one write per accepted GrantData beat, in the same cycle.
  assign data_we_o    = d_hs_s & is_data_s;
  assign data_index_o = line_q[INDEX_W-1:0];
  assign data_way_o   = way_q;
  assign data_beat_o  = beat_q;
  assign data_wdata_o = d_data_i;

  // Tag array: written on the final data beat only if no beat so far
  // (including this one) flagged an error; the permission follows the cap
  // captured on the first beat.
  assign tag_we_o   = d_hs_s & is_data_s & (beat_q == LAST_BEAT) & ~err_now_s;
  assign tag_o      = line_q[INDEX_W +: TAG_W];
  assign tag_perm_o = cap_to_perm(param_q);

endmodule

// File: tb/tb_rv64g_l1_vlsu_refill_engine.sv
// Self-checking bench for the refill engine. The bench plays the L2 side on
// a cycle timeline it chooses itself; expected outputs come from a
// transaction-level model of the refill rules.
module tb_rv64g_l1_vlsu_refill_engine;

  localparam int TAG_W     = 53;
  localparam int INDEX_W   = 5;
  localparam int WAY_W     = 2;
  localparam int DATA_W    = 64;
  localparam int SRC_W     = 4;
  localparam int SINK_W    = 4;
  localparam int SOURCE_ID = 0;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               refill_req_i;
  logic [63:0]        refill_addr_i;
  logic               refill_excl_i;
  logic [WAY_W-1:0]   victim_way_i;
  logic               refill_done_o;
  logic               refill_err_o;
  logic               busy_o;
  logic               a_valid_o;
  logic               a_ready_i;
  logic [2:0]         a_opcode_o;
  logic [2:0]         a_param_o;
  logic [3:0]         a_size_o;
  logic [SRC_W-1:0]   a_source_o;
  logic [63:0]        a_address_o;
  logic               d_valid_i;
  logic               d_ready_o;
  logic [2:0]         d_opcode_i;
  logic [1:0]         d_param_i;
  logic [SRC_W-1:0]   d_source_i;
  logic [SINK_W-1:0]  d_sink_i;
  logic               d_denied_i;
  logic               d_corrupt_i;
  logic [DATA_W-1:0]  d_data_i;
  logic               e_valid_o;
  logic               e_ready_i;
  logic [SINK_W-1:0]  e_sink_o;
  logic               data_we_o;
  logic [INDEX_W-1:0] data_index_o;
  logic [WAY_W-1:0]   data_way_o;
  logic [2:0]         data_beat_o;
  logic [DATA_W-1:0]  data_wdata_o;
  logic               tag_we_o;
  logic [TAG_W-1:0]   tag_o;
  logic [1:0]         tag_perm_o;

  rv64g_l1_vlsu_refill_engine #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .WAY_W(WAY_W), .DATA_W(DATA_W),
    .SRC_W(SRC_W), .SINK_W(SINK_W), .SOURCE_ID(SOURCE_ID)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .refill_req_i(refill_req_i), .refill_addr_i(refill_addr_i),
    .refill_excl_i(refill_excl_i), .victim_way_i(victim_way_i),
    .refill_done_o(refill_done_o), .refill_err_o(refill_err_o), .busy_o(busy_o),
    .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
    .a_param_o(a_param_o), .a_size_o(a_size_o), .a_source_o(a_source_o),
    .a_address_o(a_address_o),
    .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
    .d_param_i(d_param_i), .d_source_i(d_source_i), .d_sink_i(d_sink_i),
    .d_denied_i(d_denied_i), .d_corrupt_i(d_corrupt_i), .d_data_i(d_data_i),
    .e_valid_o(e_valid_o), .e_ready_i(e_ready_i), .e_sink_o(e_sink_o),
    .data_we_o(data_we_o), .data_index_o(data_index_o), .data_way_o(data_way_o),
    .data_beat_o(data_beat_o), .data_wdata_o(data_wdata_o),
    .tag_we_o(tag_we_o), .tag_o(tag_o), .tag_perm_o(tag_perm_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all_quiet(input string tag);
    check_val({tag, "_a_valid"}, a_valid_o, 64'd0);
    check_val({tag, "_d_ready"}, d_ready_o, 64'd0);
    check_val({tag, "_e_valid"}, e_valid_o, 64'd0);
    check_val({tag, "_data_we"}, data_we_o, 64'd0);
    check_val({tag, "_tag_we"}, tag_we_o, 64'd0);
    check_val({tag, "_done"}, refill_done_o, 64'd0);
    check_val({tag, "_err"}, refill_err_o, 64'd0);
    check_val({tag, "_busy"}, busy_o, 64'd0);
  endtask

  task automatic idle_d();
    d_valid_i = 1'b0; d_opcode_i = 3'd0; d_param_i = 2'd0; d_source_i = 4'd0;
    d_sink_i = 4'd0; d_denied_i = 1'b0; d_corrupt_i = 1'b0; d_data_i = 64'd0;
  endtask

  // err_kind: 0 none, 1 denied, 2 corrupt, 3 wrong source (on beat err_beat).
  // abort_beat >= 0 drops reset while that beat is presented.
  task automatic run_txn(input logic [63:0] addr, input bit excl, input logic [1:0] way,
                         input int a_st, input int e_st, input logic [2:0] opc,
                         input logic [1:0] prm, input int err_kind, input int err_beat,
                         input int d_prob, input bit spurious, input int abort_beat);
    int          nb;
    bit          exp_err;
    logic [1:0]  exp_perm;
    logic [3:0]  sink;
    int          beat;
    int          nstall;
    bit          dv;
    bit          exp_we;
    bit          exp_tw;
    logic [63:0] data;

    // Transaction-level expectations
    nb       = (opc == 3'd5) ? 8 : 1;
    exp_err  = (err_kind != 0 && err_beat < nb) || (opc != 3'd5) || (prm == 2'd2);
    exp_perm = (prm == 2'd0) ? 2'd2 : 2'd1;
    sink     = 4'($urandom_range(0, 15));

    // Cycle 0: request in IDLE
    @(negedge clk_i);
    check_val("idle_busy", busy_o, 64'd0);
    check_val("idle_a_valid", a_valid_o, 64'd0);
    refill_req_i = 1'b1; refill_addr_i = addr; refill_excl_i = excl; victim_way_i = way;

    // Channel A, a_st stall cycles then the handshake
    for (int c = 0; c <= a_st; c++) begin
      @(negedge clk_i);
      refill_req_i  = 1'b0;
      refill_addr_i = {$urandom, $urandom};
      refill_excl_i = ~excl;
      victim_way_i  = ~way;
      a_ready_i     = (c == a_st);
      #1;
      check_val("a_valid", a_valid_o, 64'd1);
      check_val("a_busy", busy_o, 64'd1);
      check_val("a_done", refill_done_o, 64'd0);
      if (c == a_st) begin
        check_val("a_opcode", a_opcode_o, 64'd6);
        check_val("a_param", a_param_o, {63'd0, excl});
        check_val("a_size", a_size_o, 64'd6);
        check_val("a_source", a_source_o, SOURCE_ID);
        check_val("a_address", a_address_o, {addr[63:6], 6'd0});
      end
    end

    // Channel D, bench-chosen stalls between beats
    beat = 0;
    nstall = 0;
    while (beat < nb) begin
      @(negedge clk_i);
      a_ready_i = 1'b0;
      dv = (nstall >= 4) || ($urandom_range(0, 99) < d_prob) || (beat == abort_beat);
      nstall = dv ? 0 : nstall + 1;
      data = {$urandom, $urandom};
      d_valid_i   = dv;
      d_opcode_i  = opc;
      d_param_i   = prm;
      d_sink_i    = sink;
      d_source_i  = (err_kind == 3 && beat == err_beat) ? 4'd5 : 4'(SOURCE_ID);
      d_denied_i  = (err_kind == 1 && beat == err_beat);
      d_corrupt_i = (err_kind == 2 && beat == err_beat);
      d_data_i    = data;
      refill_req_i = spurious && (beat == 2);
      if (beat == abort_beat) begin
        rst_ni = 1'b0;
        #1;
        check_all_quiet("rst_mid");
        @(negedge clk_i);
        idle_d();
        @(negedge clk_i);
        rst_ni = 1'b1;
        return;
      end
      #1;
      check_val("d_ready", d_ready_o, 64'd1);
      check_val("d_done", refill_done_o, 64'd0);
      if (dv) begin
        exp_we = (opc == 3'd5);
        exp_tw = (opc == 3'd5) && (beat == 7) && !exp_err;
        check_val("data_we", data_we_o, {63'd0, exp_we});
        if (exp_we) begin
          check_val("data_beat", data_beat_o, beat);
          check_val("data_wdata", data_wdata_o, data);
          check_val("data_index", data_index_o, addr[10:6]);
          check_val("data_way", data_way_o, way);
        end
        check_val("tag_we", tag_we_o, {63'd0, exp_tw});
        if (exp_tw) begin
          check_val("tag", tag_o, addr[63:11]);
          check_val("tag_perm", tag_perm_o, exp_perm);
        end
        beat++;
      end else begin
        check_val("stall_data_we", data_we_o, 64'd0);
        check_val("stall_tag_we", tag_we_o, 64'd0);
      end
    end

    // Channel E, e_st stall cycles then the handshake
    for (int c = 0; c <= e_st; c++) begin
      @(negedge clk_i);
      idle_d();
      refill_req_i = 1'b0;
      e_ready_i = (c == e_st);
      #1;
      check_val("e_valid", e_valid_o, 64'd1);
      check_val("e_d_ready", d_ready_o, 64'd0);
      check_val("e_done", refill_done_o, 64'd0);
      if (c == e_st) check_val("e_sink", e_sink_o, sink);
    end

    // Completion cycle
    @(negedge clk_i);
    e_ready_i = 1'b0;
    #1;
    check_val("done", refill_done_o, 64'd1);
    check_val("done_err", refill_err_o, {63'd0, exp_err});
    check_val("done_e_valid", e_valid_o, 64'd0);
  endtask

  initial begin
    logic [63:0] addr;
    int          r;
    logic [2:0]  opc;
    logic [1:0]  prm;
    int          ek;
    int          eb;

    rst_ni = 1'b0;
    refill_req_i = 1'b0; refill_addr_i = 64'd0; refill_excl_i = 1'b0; victim_way_i = 2'd0;
    a_ready_i = 1'b0; e_ready_i = 1'b0;
    idle_d();
    #2;
    check_all_quiet("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Plain NtoB fill, no stalls
    run_txn(64'h0000_0000_8000_1040, 1'b0, 2'd2, 0, 0, 3'd5, 2'd1, 0, 0, 100, 1'b0, -1);
    // NtoT fill granted toT with 3 cycles of A backpressure
    run_txn(64'h0000_0012_3456_7AC0, 1'b1, 2'd1, 3, 0, 3'd5, 2'd0, 0, 0, 100, 1'b0, -1);
    // Corrupt beat 4
    run_txn(64'h0000_0000_4000_0FC0, 1'b0, 2'd3, 0, 1, 3'd5, 2'd1, 2, 4, 100, 1'b0, -1);
    // Single-beat Grant
    run_txn(64'h0000_0000_2000_0080, 1'b1, 2'd0, 1, 0, 3'd4, 2'd0, 0, 0, 100, 1'b0, -1);
    // Request pulsed while in GRANT must be ignored
    run_txn(64'h0000_00AB_CDEF_0140, 1'b0, 2'd1, 0, 0, 3'd5, 2'd1, 0, 0, 60, 1'b1, -1);
    // Reset during beat 5, then a normal fill
    run_txn(64'h0000_0000_1111_2200, 1'b1, 2'd2, 0, 0, 3'd5, 2'd0, 0, 0, 100, 1'b0, 5);
    run_txn(64'h0000_0000_3333_4440, 1'b1, 2'd0, 0, 0, 3'd5, 2'd0, 0, 0, 100, 1'b0, -1);

    // Randomized fills, back to back
    for (int i = 0; i < 40; i++) begin
      addr = {$urandom, $urandom};
      r    = $urandom_range(0, 9);
      opc  = (r == 0) ? 3'd4 : 3'd5;
      prm  = (r == 1) ? 2'd2 : 2'($urandom_range(0, 1));
      ek   = (r >= 2 && r <= 4) ? r - 1 : 0;
      eb   = (opc == 3'd4) ? 0 : $urandom_range(0, 7);
      run_txn(addr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom_range(0, 3), $urandom_range(0, 3), opc, prm, ek, eb,
              70, 1'($urandom_range(0, 1)), -1);
    end

    @(negedge clk_i);
    #1;
    check_val("final_busy", busy_o, 64'd0);
    check_val("final_a_valid", a_valid_o, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
